// File: rtl/cdb_pkg.sv
// Shared CDB defaults: rename tag / result widths and functional unit indices.
// Used by the CDB arbiter, free-tag FIFO and reservation stations.
package cdb_pkg;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_NUM_FU = 4;

    localparam int FU_ALU = 0;
    localparam int FU_MUL = 1;
    localparam int FU_DIV = 2;
    localparam int FU_LSU = 3;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans req from ptr upward, wrapping,
// and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant, registered {tag,data} broadcast.
// Define CDB_PERF_EN to add the saturating cdb_conflict_cnt output.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = CDB_NUM_FU,
    parameter int TAG_WIDTH  = CDB_TAG_W,
    parameter int DATA_WIDTH = CDB_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [NUM_FU-1:0]            fu_valid,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
    output logic [NUM_FU-1:0]            fu_grant,
    output logic                         cdb_valid,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [DATA_WIDTH-1:0]        cdb_data
`ifdef CDB_PERF_EN
    ,
    output logic [15:0]                  cdb_conflict_cnt
`endif
);

    localparam int PW = $clog2(NUM_FU);

    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         gnt_idx;
    logic                  any_gnt;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;

    // Reset and flush both gate the grant so no request is consumed.
    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req    (fu_valid),
        .ptr    (rr_ptr_q),
        .en     (reset & ~flush),
        .gnt    (fu_grant),
        .gnt_idx(gnt_idx)
    );

    assign any_gnt = |fu_grant;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        if (any_gnt) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = fu_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH];
            cdb_data_d  = fu_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            if (int'(gnt_idx) == NUM_FU - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

`ifdef CDB_PERF_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        conflict;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign conflict = |(fu_valid & (fu_valid - NUM_FU'(1)));

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (!flush && conflict && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign cdb_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: FU request queues, reference round-robin
// model, expected broadcasts queued at grant time and popped after the edge.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int QD = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    fu_valid;
    logic [N*TW-1:0] fu_tag;
    logic [N*DW-1:0] fu_data;
    logic [N-1:0]    fu_grant;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
`ifdef CDB_PERF_EN
    logic [15:0]     cdb_conflict_cnt;
`endif

    cdb_arbiter #(.NUM_FU(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .fu_valid (fu_valid),
        .fu_tag   (fu_tag),
        .fu_data  (fu_data),
        .fu_grant (fu_grant),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data)
`ifdef CDB_PERF_EN
        ,
        .cdb_conflict_cnt(cdb_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [TW-1:0] t;
        logic [DW-1:0] d;
    } bus_t;

    bus_t          sb[$];
    logic [TW-1:0] logq[$];
    logic [TW-1:0] pt[N][QD];
    logic [DW-1:0] pd[N][QD];
    int            head[N];
    int            tail[N];
    bit            sticky;

    int            m_ptr;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    logic [15:0]   m_cnt;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int fu, input logic [TW-1:0] t);
        if (tail[fu] < QD) begin
            pt[fu][tail[fu]] = t;
            pd[fu][tail[fu]] = $urandom;
            tail[fu]++;
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (tail[i] != head[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            fu_valid[i]           = (tail[i] != head[i]);
            fu_tag[i*TW +: TW]    = (tail[i] != head[i]) ? pt[i][head[i]] : '0;
            fu_data[i*DW +: DW]   = (tail[i] != head[i]) ? pd[i][head[i]] : '0;
        end
    endtask

    // One clock: check the grant, predict the bus, advance, check the bus.
    task automatic step();
        bus_t       e;
        int         g = -1;
        int         nreq = 0;
        logic [N-1:0] eg = '0;
        drive();
        #1;
        for (int i = 0; i < N; i++) begin
            if (fu_valid[i]) nreq++;
        end
        if (reset && !flush) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && fu_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("fu_grant", 64'(fu_grant), 64'(eg));
        if (!reset) begin
            m_cnt = '0;
        end else if (!flush && nreq >= 2 && m_cnt != 16'hFFFF) begin
            m_cnt = m_cnt + 16'd1;
        end
        if (!reset) begin
            m_ptr  = 0;
            m_tag  = '0;
            m_data = '0;
            e      = '{v: 1'b0, t: '0, d: '0};
        end else if (g >= 0) begin
            m_tag  = pt[g][head[g]];
            m_data = pd[g][head[g]];
            m_ptr  = (g + 1) % N;
            e      = '{v: 1'b1, t: m_tag, d: m_data};
            logq.push_back(m_tag);
            if (!sticky) head[g]++;
        end else begin
            e = '{v: 1'b0, t: m_tag, d: m_data};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
        chk("cdb_tag", 64'(cdb_tag), 64'(e.t));
        chk("cdb_data", 64'(cdb_data), 64'(e.d));
`ifdef CDB_PERF_EN
        chk("conflict_cnt", 64'(cdb_conflict_cnt), 64'(m_cnt));
`endif
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (!pending()) break;
            step();
        end
        chk("drain_timeout", 64'(pending()), 64'd0);
        step();
    endtask

    task automatic chk_log(input string tag, input int n,
                           input logic [TW-1:0] a, input logic [TW-1:0] b,
                           input logic [TW-1:0] c, input logic [TW-1:0] d);
        logic [TW-1:0] ex[4];
        ex = '{a, b, c, d};
        chk({tag, "_len"}, 64'(logq.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk(tag, 64'((i < logq.size()) ? logq[i] : '1), 64'(ex[i]));
        end
        logq.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sticky      = 1'b0;
        m_ptr       = 0;
        m_tag       = '0;
        m_data      = '0;
        m_cnt       = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        reset = 1'b0;
        flush = 1'b0;
        drive();
        @(posedge clk);
        @(negedge clk);

        // Reset held with all FUs requesting.
        for (int i = 0; i < N; i++) push(i, TW'(i + 1));
        step();
        step();
        reset = 1'b1;
        drain();
        chk_log("after_reset", 4, 6'd1, 6'd2, 6'd3, 6'd4);

        // Single requester, back-to-back.
        push(2, 6'd5);
        push(2, 6'd6);
        push(2, 6'd7);
        drain();
        chk_log("single", 3, 6'd5, 6'd6, 6'd7, 6'd0);

        // Park pointer at 0, then full rotation.
        push(3, 6'd30);
        drain();
        logq.delete();
        for (int i = 0; i < N; i++) push(i, TW'(10 + i));
        drain();
        chk_log("rotate", 4, 6'd10, 6'd11, 6'd12, 6'd13);
        push(0, 6'd20);
        push(3, 6'd23);
        drain();
        chk_log("rerequest", 2, 6'd20, 6'd23, 6'd0, 6'd0);

        // Pointer at 3, only FU0 requests; then prove pointer is 1.
        push(2, 6'd40);
        drain();
        logq.delete();
        push(0, 6'd63);
        drain();
        chk_log("wrap", 1, 6'd63, 6'd0, 6'd0, 6'd0);
        push(0, 6'd44);
        push(1, 6'd41);
        drain();
        chk_log("wrap_ptr", 2, 6'd41, 6'd44, 6'd0, 6'd0);

        // Flush suppresses grant; FU1 holds and wins afterwards.
        push(0, 6'd21);
        step();
        push(1, 6'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain();
        chk_log("flush", 2, 6'd21, 6'd9, 6'd0, 6'd0);

        // Reset in the middle of a burst.
        for (int i = 0; i < N; i++) push(i, TW'(50 + i));
        step();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        drain();
        logq.delete();

        // Random traffic with occasional flush.
        for (int c = 0; c < 150; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0 && tail[i] - head[i] < 4) begin
                    push(i, TW'($urandom_range(0, 63)));
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            step();
        end
        flush = 1'b0;
        drain();
        logq.delete();

`ifdef CDB_PERF_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(1, TW'(k));
            push(2, TW'(k + 8));
        end
        for (int k = 0; k < 6; k++) step();
        for (int k = 0; k < 3; k++) push(0, TW'(k + 16));
        drain();
        chk("perf_cnt5", 64'(cdb_conflict_cnt), 64'd5);
        logq.delete();
        push(0, 6'd1);
        push(1, 6'd2);
        sticky = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            step();
            logq.delete();
        end
        chk("perf_sat", 64'(cdb_conflict_cnt), 64'hFFFF);
        sticky = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Producer end of the tag-return path. Arbitrates the completing functional units onto the single Common Data Bus (CDB).
- Broadcasts one {tag, data} per cycle. cdb_tag/cdb_valid feed the free-tag FIFO's write side (cdb_tag_tf/cdb_tag_tf_valid) plus the reservation stations and register status table.
- Round-robin fairness; a requesting FU holds its request until it is granted.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8).
- TAG_WIDTH, 6, width of a rename tag.
- DATA_WIDTH, 32, width of a result word.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  pipeline flush (branch mispredict); kills in-flight broadcast.
- fu_valid  in  NUM_FU  per-FU result request; bit i = FU i.
- fu_tag  in  NUM_FU*TAG_WIDTH  flattened tags; slice i = [i*TAG_WIDTH +: TAG_WIDTH].
- fu_data  in  NUM_FU*DATA_WIDTH  flattened results, same slicing.
- fu_grant  out  NUM_FU  one-hot, combinational; FU i's request is consumed at this clock edge.
- cdb_valid  out  1  registered broadcast valid.
- cdb_tag  out  TAG_WIDTH  registered broadcast tag.
- cdb_data  out  DATA_WIDTH  registered broadcast data.

Behaviour:
- Reset (reset==0 at posedge):
  - cdb_valid=0, cdb_tag=0, cdb_data=0.
  - Round-robin pointer rr_ptr=0.
  - fu_grant=0 while reset is low.
- Grant (combinational):
  - Scan fu_valid starting at index rr_ptr, ascending, wrapping modulo NUM_FU.
  - The first set bit receives fu_grant.
  - At most one grant bit is high.
  - No grant when fu_valid==0, when flush==1, or when reset==0.
- Broadcast:
  - If grant to FU g at edge N, then from N+1: cdb_valid=1, cdb_tag=fu_tag[g], cdb_data=fu_data[g], sampled at edge N.
  - One-cycle latency, request to bus.
  - With no grant, cdb_valid=0 next cycle; cdb_tag/cdb_data hold their previous values.
- Pointer update:
  - On a grant to g, rr_ptr <= (g+1) mod NUM_FU.
  - Otherwise rr_ptr holds.
- FU handshake:
  - An FU keeps fu_valid/fu_tag/fu_data stable until it sees fu_grant[i]=1.
  - It may drop fu_valid or present a new result in the cycle after the grant.
  - The arbiter never drops or duplicates an accepted request.
- Flush:
  - flush==1 at an edge forces cdb_valid=0 next cycle and suppresses the grant that cycle.
  - rr_ptr holds.
  - A broadcast already on the bus during the flush cycle completes normally; the flush only affects the next cycle.
- Starvation bound: a continuously requesting FU is granted within NUM_FU cycles of first request (flush cycles excluded).
- Boundary cases:
  - Single requester: granted every cycle (back-to-back broadcasts).
  - All requesting: strict rotation 0,1,2,3,0...
  - rr_ptr at NUM_FU-1 with only FU0 requesting: FU0 granted, pointer wraps to 1.
  - Reset mid-broadcast: cdb_valid=0 next cycle; pending requests are ignored until reset releases.

Optional Feature:
- Macro: CDB_PERF_EN.
- Defined:
  - Adds output port cdb_conflict_cnt [15:0].
  - 16-bit counter increments on every non-reset, non-flush cycle with two or more fu_valid bits set.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header cdb_pkg:
  - Default TAG_WIDTH and DATA_WIDTH, kept shared with the free-tag FIFO and reservation stations.
  - FU index constants: FU_ALU=0, FU_MUL=1, FU_DIV=2, FU_LSU=3.
  - NUM_FU default.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[log2 N], en.
  - Outputs: gnt[N] one-hot, gnt_idx.
  - Purely combinational rotate–priority–unrotate.
- cdb_arbiter wraps it with the pointer register, output registers, mux and flush gating.

Test Plan:
- Reset: hold reset=0 two cycles with fu_valid=4'b1111 -> fu_grant=0, cdb_valid=0, cdb_tag=0; after release, first grant goes to FU0.
- Single requester: FU2 requests tags 6'd5,6'd6,6'd7 on consecutive cycles, each dropped after grant -> cdb_tag = 5,6,7 on consecutive cycles from one cycle after first request, cdb_valid=1 for 3 cycles.
- Rotation: all four FUs hold tags 10,11,12,13 -> broadcast order 10,11,12,13. Then FU0 re-requests tag 20 while FU3 re-requests tag 23 with rr_ptr=0 -> 20 before 23.
- Wrap: rr_ptr=3, only FU0 requests tag 6'd63 -> grant FU0, cdb_tag=63 next cycle, rr_ptr=1.
- Flush: FU1 requests tag 9 with flush=1 the same cycle -> no grant, cdb_valid=0 next cycle. FU1 holds; granted the cycle after flush deasserts, cdb_tag=9.
- CDB_PERF_EN: 5 cycles with fu_valid=4'b0110, 3 cycles with 4'b0001 -> cdb_conflict_cnt=5. Force to 16'hFFFF then conflict -> stays 16'hFFFF.
